// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Reserved size is folded in here so one call covers every non-range fault.
  function automatic logic align_fault(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/Data_Memory.sv
// Word-organised data memory: write on posedge, read data updated on negedge while MemRead.
// Contents clear on reset.
module Data_Memory #(
  parameter int AW = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData
);

  logic [(1<<AW)-1:0][31:0] mem_q;
  logic [AW-1:0]            idx;
  logic                     unused_addr_bits;

  assign idx              = address[AW+1:2];
  assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else if (MemWrite) begin
      mem_q[idx] <= WriteData;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ReadData <= '0;
    end else if (MemRead) begin
      ReadData <= mem_q[idx];
    end
  end

endmodule

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts and extends sub-word loads, merges sub-word stores
// into the previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        signed_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w  = rword_i[{addr_i, 3'b000} +: 8];
    half_w  = rword_i[{addr_i[1], 4'b0000} +: 16];
    load_o  = rword_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & byte_w[7]}}, byte_w};
        merge_o = rword_i;
        merge_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{signed_i & half_w[15]}}, half_w};
        merge_o = rword_i;
        merge_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = rword_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the word data memory; sub-word stores use
// read-modify-write, faults respond in one cycle without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_AW   = 7,
  parameter bit CHECK_OOR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_WriteData,
  input  logic [31:0] ReadData
);

  lsu_state_e  state_q, accept_state_d;
  logic        wr_q, sgn_q, err_q, fault_d;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rbuf_q, rdata_q;
  logic [31:0] align_word, load_val, merge_val;

  assign fault_d = align_fault(req_size, req_addr[1:0])
                 | (CHECK_OOR && (|req_addr[31:DMEM_AW+2]));

  always_comb begin
    accept_state_d = RD;
    if (fault_d) begin
      accept_state_d = DONE;
    end else if (req_write && (req_size == SZ_WORD)) begin
      accept_state_d = WR;
    end
  end

  // During RD the load result is taken straight from ReadData as it is captured.
  assign align_word = (state_q == RD) ? ReadData : rbuf_q;

  lsu_lane_align u_align (
    .size_i   (size_q),
    .addr_i   (addr_q[1:0]),
    .signed_i (sgn_q),
    .rword_i  (align_word),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            sgn_q   <= req_signed;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= fault_d;
            if (fault_d) begin
              rdata_q <= '0;
            end
            state_q <= accept_state_d;
          end
        end
        RD: begin
          rbuf_q <= ReadData;
          if (wr_q) begin
            state_q <= WR;
          end else begin
            rdata_q <= load_val;
            state_q <= DONE;
          end
        end
        WR: begin
          rdata_q <= '0;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_err      = (state_q == DONE) & err_q;
  assign resp_rdata    = rdata_q;
  assign MemRead       = (state_q == RD);
  assign MemWrite      = (state_q == WR);
  assign mem_address   = {addr_q[31:2], 2'b00};
  assign mem_WriteData = (state_q == WR) ? merge_val : '0;

endmodule
